uart_tx_wb_slave: RTL and testbench

- Wishbone classic slave holding the UART transmit register set that the control-unit master programs: baud, TX buffer, control/start and status.
- Serialises one 8N1 frame per start command on tx_o.
- Raises a sticky done flag in STATUS bit 5, which the master polls and then clears by writing STATUS.
- Sits between the system Wishbone bus and the UART TX pin.

---
 rtl/uart_tx_wb_slave.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_tx_wb_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_wb_slave.sv
// -----------------------------------------------------------------------------
// uart_tx_wb_slave
//
// Wishbone classic slave that holds the UART transmit register set and
// serialises one frame per start command onto tx_o. The frame is one start
// bit, DATA_BITS payload bits (LSB first), an optional parity bit and one
// stop bit. Bit timing comes from a 32-bit phase accumulator: every carry
// out of acc + BAUD is one bit time.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : CTRL bit1 selects even(0)/odd(1) parity and a parity bit is
//               sent between the last data bit and the stop bit.
//   undefined : no parity bit; CTRL bit1 reads 0 and ignores writes.
//
// Register map (word addresses):
//   0x3 CTRL   W: bit7 start   R: bit7 busy, bit1 odd parity select
//   0x4 BAUD   R/W 32-bit phase increment
//   0x5 STATUS R: bit5 done, bit0 busy   W: any write clears done
//   0x7 TXBUF  R/W bits [7:0]
//
// Ports:
//   clk_i        system clock, rising edge
//   async_rst_i  asynchronous active-low reset
//   addr_i       word address
//   dat_i/dat_o  write / registered read data
//   we_i         1 = write, 0 = read
//   sel_i        byte selects, unused (full-word accesses only)
//   cyc_i/stb_i  bus cycle / strobe
//   ack_o        one-cycle acknowledge for mapped addresses
//   err_o        one-cycle error for unmapped addresses
//   tx_o         serial output, idles high
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | line idle (tx high), waiting for a start command
//   S_START  | start bit (tx low) for one bit time
//   S_DATA   | payload bits from shift_q[0], DATA_BITS bit times
//   S_PARITY | parity bit for one bit time (parity builds only)
//   S_STOP   | stop bit (tx high); end of this bit sets done
// -----------------------------------------------------------------------------
module uart_tx_wb_slave #(
  parameter logic [31:0] RESET_BAUD = 32'h0000_0000,
  parameter int          DATA_BITS  = 8
) (
  input  logic        clk_i,
  input  logic        async_rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        tx_o
);

  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0003;
  localparam logic [31:0] ADDR_BAUD   = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0005;
  localparam logic [31:0] ADDR_TXBUF  = 32'h0000_0007;

  localparam logic [3:0]  LAST_BIT    = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0] baud_q;
  logic [7:0]  txbuf_q;
  logic        done_q;
  logic [31:0] acc_q;
  logic [7:0]  shift_q;
  logic [3:0]  bit_cnt_q;

  logic        req;
  logic        mapped;
  logic [31:0] rd_data;
  logic        wr_en;
  logic        start_cmd;
  logic        start_go;
  logic        stop_done;
  logic [32:0] sum;
  logic        tick;
  logic        busy;
  logic        tx_c;
  logic        last_bit;

`ifdef UART_TX_PARITY_EN
  logic        parity_odd_q;
  logic [7:0]  data_q;
  logic        parity_bit;
`endif

  // sel_i is accepted for bus compatibility only.
  logic unused_sel;
  assign unused_sel = ^sel_i;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  // Gating on ack_o/err_o makes a held strobe produce one transfer every two
  // cycles instead of one per cycle.
  assign req = cyc_i & stb_i & ~ack_o & ~err_o;

  always_comb begin
    mapped  = 1'b0;
    rd_data = '0;
    case (addr_i)
      ADDR_CTRL: begin
        mapped     = 1'b1;
        rd_data[7] = busy;
`ifdef UART_TX_PARITY_EN
        rd_data[1] = parity_odd_q;
`endif
      end
      ADDR_BAUD: begin
        mapped  = 1'b1;
        rd_data = baud_q;
      end
      ADDR_STATUS: begin
        mapped     = 1'b1;
        rd_data[5] = done_q;
        rd_data[0] = busy;
      end
      ADDR_TXBUF: begin
        mapped       = 1'b1;
        rd_data[7:0] = txbuf_q;
      end
      default: begin
        mapped  = 1'b0;
        rd_data = '0;
      end
    endcase
  end

  assign wr_en     = req & mapped & we_i;
  assign start_cmd = wr_en & (addr_i == ADDR_CTRL) & dat_i[7];
  // A start is only honoured from IDLE; in STOP busy is still 1, so a start
  // on the completing edge is dropped too.
  assign start_go  = start_cmd & (state_q == S_IDLE);

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req & mapped;
      err_o <= req & ~mapped;
      dat_o <= (req & mapped & ~we_i) ? rd_data : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      baud_q  <= RESET_BAUD;
      txbuf_q <= '0;
    end else if (wr_en) begin
      case (addr_i)
        ADDR_BAUD:  baud_q  <= dat_i;
        ADDR_TXBUF: txbuf_q <= dat_i[7:0];
        default:    ;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      parity_odd_q <= 1'b0;
    end else if (wr_en && (addr_i == ADDR_CTRL)) begin
      parity_odd_q <= dat_i[1];
    end
  end
`endif

  assign stop_done = (state_q == S_STOP) & tick;

  // Completion has priority over a clearing write in the same cycle so a
  // finished frame is never lost.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      done_q <= 1'b0;
    end else if (stop_done) begin
      done_q <= 1'b1;
    end else if (wr_en && (addr_i == ADDR_STATUS)) begin
      done_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-rate accumulator
  // ---------------------------------------------------------------------------
  assign sum  = {1'b0, acc_q} + {1'b0, baud_q};
  assign tick = sum[32];

  // BAUD = 0 leaves acc unchanged and never carries, which freezes the frame.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      acc_q <= '0;
    end else if (start_go) begin
      acc_q <= '0;
    end else if (state_q != S_IDLE) begin
      acc_q <= sum[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath
  // ---------------------------------------------------------------------------
  assign last_bit = (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (start_go) begin
      shift_q   <= txbuf_q;
      bit_cnt_q <= '0;
    end else if ((state_q == S_DATA) && tick) begin
      shift_q   <= {1'b0, shift_q[7:1]};
      bit_cnt_q <= bit_cnt_q + 4'd1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Keep an unshifted copy of the payload for the parity bit; TXBUF itself
  // may be rewritten while the frame is in flight.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      data_q <= '0;
    end else if (start_go) begin
      data_q <= txbuf_q;
    end
  end

  assign parity_bit = (^data_q[DATA_BITS-1:0]) ^ parity_odd_q;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_cmd) state_d = S_START;
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // tx_o decodes straight from the state register so reset drives the line
  // high immediately, without waiting for a clock.
  always_comb begin
    tx_c = 1'b1;
    busy = 1'b1;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_START:  tx_c = 1'b0;
      S_DATA:   tx_c = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_c = parity_bit;
`endif
      S_STOP:   tx_c = 1'b1;
      default: begin
        tx_c = 1'b1;
        busy = 1'b1;
      end
    endcase
  end

  assign tx_o = tx_c;

endmodule

// File: tb/tb_uart_tx_wb_slave.sv
// -----------------------------------------------------------------------------
// Bench for uart_tx_wb_slave. The reference model keeps the frame as a queue
// of line levels (start, data LSB first, optional parity, stop) and pops one
// entry per accumulator carry; bus responses come from the register map.
// -----------------------------------------------------------------------------
module tb_uart_tx_wb_slave;

  localparam logic [31:0] RESET_BAUD = 32'h0000_0000;
  localparam int          DATA_BITS  = 8;

  logic        clk_i = 1'b0;
  logic        async_rst_i;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic        err_o;
  logic        tx_o;

  uart_tx_wb_slave #(
    .RESET_BAUD (RESET_BAUD),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .addr_i      (addr_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .we_i        (we_i),
    .sel_i       (sel_i),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .tx_o        (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_ack, m_err;
  logic [31:0] m_dat;
  bit          m_active;
  bit          m_q[$];
  logic [31:0] m_acc, m_baud;
  logic [7:0]  m_txbuf;
  bit          m_done, m_odd;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    return (a == 32'h3) || (a == 32'h4) || (a == 32'h5) || (a == 32'h7);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      32'h3: begin
        if (m_active) r = r + 32'h80;
`ifdef UART_TX_PARITY_EN
        if (m_odd) r = r + 32'h2;
`endif
      end
      32'h4: r = m_baud;
      32'h5: begin
        if (m_done)   r = r + 32'h20;
        if (m_active) r = r + 32'h1;
      end
      32'h7: r = {24'h0, m_txbuf};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic build_frame(input logic [7:0] d, input bit odd);
    bit p;
    p = odd;
    m_q.delete();
    m_q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      m_q.push_back(d[i]);
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    m_q.push_back(p);
`endif
    m_q.push_back(1'b1);
  endtask

  task automatic model_reset();
    m_ack = 0; m_err = 0; m_dat = 0;
    m_active = 0; m_q.delete();
    m_acc = 0; m_baud = RESET_BAUD; m_txbuf = 0;
    m_done = 0; m_odd = 0;
  endtask

  function automatic bit ends_next();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, m_baud};
    return m_active && (m_q.size() == 1) && s[32];
  endfunction

  // Advance one clock: update the model for the coming edge, then compare.
  task automatic step();
    bit req, map, was_active, end_now, exp_tx;
    logic [32:0] s;
    logic [31:0] rd;
    req = cyc_i && stb_i && !m_ack && !m_err;
    map = is_mapped(addr_i);
    rd  = model_read(addr_i);
    was_active = m_active;
    end_now = 0;
    if (m_active) begin
      s = {1'b0, m_acc} + {1'b0, m_baud};
      m_acc = s[31:0];
      if (s[32]) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 0;
          end_now = 1;
        end
      end
    end
    if (req && map && we_i) begin
      case (addr_i)
        32'h3: begin
`ifdef UART_TX_PARITY_EN
          m_odd = dat_i[1];
`endif
          if (dat_i[7] && !was_active) begin
            build_frame(m_txbuf, m_odd);
            m_acc = 0;
            m_active = 1;
          end
        end
        32'h4: m_baud = dat_i;
        32'h5: if (!end_now) m_done = 0;
        32'h7: m_txbuf = dat_i[7:0];
        default: ;
      endcase
    end
    if (end_now) m_done = 1;
    m_ack = req && map;
    m_err = req && !map;
    m_dat = (req && map && !we_i) ? rd : 32'h0;
    @(posedge clk_i);
    #1;
    exp_tx = m_active ? m_q[0] : 1'b1;
    check("ack", {31'h0, ack_o}, {31'h0, m_ack});
    check("err", {31'h0, err_o}, {31'h0, m_err});
    check("dat", dat_o, m_dat);
    check("tx",  {31'h0, tx_o},  {31'h0, exp_tx});
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit w, input int hold);
    cyc_i = 1; stb_i = 1; addr_i = a; dat_i = d; we_i = w;
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == 0) last_rd = dat_o;
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    step();
  endtask

  task automatic rd_const(input logic [31:0] a, input logic [31:0] exp, input string tag);
    access(a, 32'h0, 1'b0, 1);
    check(tag, last_rd, exp);
  endtask

  task automatic wait_frame(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!m_active) return;
      step();
    end
    if (m_active) timeout("frame_end");
  endtask

  initial begin
    async_rst_i = 0;
    addr_i = 0; dat_i = 0; we_i = 0; sel_i = 4'hF; cyc_i = 0; stb_i = 0;
    model_reset();
    last_rd = 0;

    // reset
    #1;
    check("rst_tx",  {31'h0, tx_o},  32'h1);
    check("rst_ack", {31'h0, ack_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 async_rst_i = 1;
    step();
    rd_const(32'h4, RESET_BAUD, "rst_baud");
    rd_const(32'h5, 32'h0, "rst_status");
    rd_const(32'h7, 32'h0, "rst_txbuf");

    // single frame, 4 clocks per bit
    access(32'h4, 32'h4000_0000, 1, 1);
    access(32'h7, 32'h41, 1, 1);
    access(32'h3, 32'h80, 1, 1);
    rd_const(32'h3, 32'h80, "busy_mid");
    rd_const(32'h5, 32'h01, "status_busy");
    wait_frame(200);
    rd_const(32'h5, 32'h20, "status_done");

    // held strobe: two acks, second start ignored
    access(32'h5, 32'h0, 1, 1);
    access(32'h7, 32'hC3, 1, 1);
    access(32'h3, 32'h80, 1, 4);
    wait_frame(200);
    repeat (20) step();
    rd_const(32'h5, 32'h20, "dbl_done");

    // clearing write on the completing edge loses to the set
    access(32'h5, 32'h0, 1, 1);
    access(32'h7, 32'h5A, 1, 1);
    access(32'h3, 32'h80, 1, 1);
    for (int i = 0; i < 200 && !ends_next(); i++) step();
    if (!ends_next()) timeout("race_align");
    access(32'h5, 32'h0, 1, 1);
    rd_const(32'h5, 32'h20, "race_done_kept");
    access(32'h5, 32'h0, 1, 1);
    rd_const(32'h5, 32'h00, "done_cleared");

    // stall with BAUD = 0, then retime
    access(32'h7, 32'hA5, 1, 1);
    access(32'h3, 32'h80, 1, 1);
    for (int i = 0; i < 200 && m_q.size() > 5; i++) step();
    access(32'h4, 32'h0, 1, 1);
    repeat (100) step();
    rd_const(32'h3, 32'h80, "stall_busy");
    access(32'h4, 32'h8000_0000, 1, 1);
    wait_frame(100);

    // unmapped address
    access(32'h9, 32'hFFFF_FFFF, 1, 1);
    rd_const(32'h9, 32'h0, "unmapped_rd");
    rd_const(32'h4, 32'h8000_0000, "baud_kept");
    rd_const(32'h7, 32'hA5, "txbuf_kept");

`ifdef UART_TX_PARITY_EN
    access(32'h5, 32'h0, 1, 1);
    access(32'h4, 32'h4000_0000, 1, 1);
    access(32'h7, 32'h52, 1, 1);
    access(32'h3, 32'h80, 1, 1);
    for (int i = 0; i < 200 && m_q.size() > 2; i++) step();
    check("parity_bit", {31'h0, tx_o}, 32'h1);
    wait_frame(100);
`endif

    // randomized frames with bus traffic during the frame
    for (int f = 0; f < 12; f++) begin
      access(32'h4, $urandom_range(32'hFFFF_FFFF, 32'h2000_0000), 1, 1);
      access(32'h7, {24'h0, 8'($urandom)}, 1, 1);
      if ($urandom_range(1, 0) == 1) access(32'h5, 32'h0, 1, 1);
      access(32'h3, m_odd ? 32'h82 : 32'h80, 1, 1);
      for (int k = 0; k < 400 && m_active; k++) begin
        case ($urandom_range(6, 0))
          0: access($urandom_range(10, 0), 32'h0, 0, $urandom_range(3, 1));
          1: access(32'h7, $urandom, 1, 1);
          2: access(32'h3, m_odd ? 32'h82 : 32'h80, 1, $urandom_range(3, 1));
          3: access(32'h5, $urandom, 1, 1);
          4: step();
          5: access(32'h5, 32'h0, 0, 1);
          default: access(32'h4, $urandom_range(32'hFFFF_FFFF, 32'h2000_0000), 1, 1);
        endcase
      end
      wait_frame(200);
      step();
    end

    // reset in mid-frame
    access(32'h4, 32'h4000_0000, 1, 1);
    access(32'h7, 32'h00, 1, 1);
    access(32'h3, 32'h80, 1, 1);
    repeat (6) step();
    #2 async_rst_i = 0;
    #1;
    check("rst_mid_tx",  {31'h0, tx_o},  32'h1);
    check("rst_mid_ack", {31'h0, ack_o}, 32'h0);
    model_reset();
    @(posedge clk_i);
    #1 async_rst_i = 1;
    repeat (3) step();
    rd_const(32'h5, 32'h0, "rst_mid_status");
    rd_const(32'h4, RESET_BAUD, "rst_mid_baud");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
